// File: rtl/sme_pkg.sv
// Shared types and limits for the SME job scheduler: FSM states, per-job
// character limits and the pattern metacharacters the engine understands.
package sme_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } sme_state_e;

  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;

  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;

endpackage

// File: rtl/sme_job_sched_if.sv
// Link between the job scheduler and the shared match engine.
interface sme_job_sched_if;

  logic [7:0] eng_chardata;
  logic       eng_isstring;
  logic       eng_ispattern;
  logic       eng_valid;
  logic       eng_match;
  logic [4:0] eng_match_index;

  modport master (
    output eng_chardata, eng_isstring, eng_ispattern,
    input  eng_valid, eng_match, eng_match_index
  );

  modport slave (
    input  eng_chardata, eng_isstring, eng_ispattern,
    output eng_valid, eng_match, eng_match_index
  );

endinterface

// File: rtl/sme_rr_arb.sv
// Two-way round-robin pick; the requester after the last served one wins a tie.
module sme_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served_idx,
  output logic [1:0] pick
);

  // index of the requester that wins when both are asking
  logic prio;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (upd) begin
      prio <= ~served_idx;
    end
  end

  always_comb begin
    pick = '0;
    if (req[prio]) begin
      pick[prio] = 1'b1;
    end else if (req[~prio]) begin
      pick[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/sme_job_sched.sv
// Shares one match engine between two requesters, one job at a time.
// Optional WAIT-state watchdog: define SME_JOB_SCHED_TIMEOUT_EN.
module sme_job_sched
  import sme_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [15:0]     req_chardata,
  input  logic [1:0]      req_isstring,
  input  logic [1:0]      req_ispattern,
  input  logic [1:0]      req_last,
  output logic [1:0]      gnt,
  sme_job_sched_if.master eng,
  output logic [1:0]      rsp_valid,
  output logic            rsp_match,
  output logic [4:0]      rsp_index,
  output logic            rsp_err
);

  sme_state_e state, state_nx;

  logic [5:0] str_cnt;
  logic [3:0] pat_cnt;
  logic       err_flag;
  logic [1:0] pick;
  logic [7:0] eng_cd;
  logic       eng_s, eng_p;

  logic       gidx, c_req, c_s, c_p, c_l;
  logic [7:0] c_d;
  logic       gap, str_ovf, pat_ovf, fwd, load_err, load_done, tmo;

  sme_rr_arb u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .upd        (state == RESP),
    .served_idx (gidx),
    .pick       (pick)
  );

  // Any LOAD cycle that is not a usable character ends the job, since the
  // engine starts comparing on the first idle input cycle.
  always_comb begin
    gidx      = gnt[1];
    c_req     = req[gidx];
    c_s       = req_isstring[gidx];
    c_p       = req_ispattern[gidx];
    c_l       = req_last[gidx];
    c_d       = gidx ? req_chardata[15:8] : req_chardata[7:0];
    gap       = !c_req || !(c_s || c_p) || (c_l && !c_p);
    str_ovf   = c_s && (str_cnt == 6'(STR_MAX));
    pat_ovf   = c_p && (pat_cnt == 4'(PAT_MAX));
    fwd       = !gap && !str_ovf && !pat_ovf;
    load_err  = gap || str_ovf || pat_ovf || (c_p && !c_s && (str_cnt == '0));
    load_done = gap || (c_l && c_p);
  end

`ifdef SME_JOB_SCHED_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign tmo = (state == WAIT) && !eng.eng_valid && (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    unique case (state)
      IDLE: if (|req) state_nx = LOAD;
      LOAD: if (load_done) state_nx = WAIT;
      WAIT: if (eng.eng_valid || tmo) state_nx = RESP;
      RESP: begin
        state_nx  = IDLE;
        rsp_valid = gnt;
        rsp_err   = err_flag;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      str_cnt   <= '0;
      pat_cnt   <= '0;
      err_flag  <= 1'b0;
      eng_cd    <= '0;
      eng_s     <= 1'b0;
      eng_p     <= 1'b0;
      rsp_match <= 1'b0;
      rsp_index <= '0;
    end else begin
      eng_cd <= '0;
      eng_s  <= 1'b0;
      eng_p  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt      <= pick;
          str_cnt  <= '0;
          pat_cnt  <= '0;
          err_flag <= 1'b0;
        end
        LOAD: begin
          if (fwd) begin
            eng_cd <= c_d;
            eng_s  <= c_s;
            eng_p  <= c_p;
            if (c_s) str_cnt <= str_cnt + 1'b1;
            if (c_p) pat_cnt <= pat_cnt + 1'b1;
          end
          if (load_err) err_flag <= 1'b1;
        end
        WAIT: if (eng.eng_valid) begin
          rsp_match <= eng.eng_match;
          rsp_index <= eng.eng_match_index;
        end else if (tmo) begin
          rsp_match <= 1'b0;
          rsp_index <= '0;
          err_flag  <= 1'b1;
        end
        RESP: gnt <= '0;
        default: ;
      endcase
    end
  end

  assign eng.eng_chardata  = eng_cd;
  assign eng.eng_isstring  = eng_s;
  assign eng.eng_ispattern = eng_p;

endmodule

// File: tb/tb_sme_job_sched.sv
// Randomised job-level bench for sme_job_sched with a character-rule reference model.
module tb_sme_job_sched;
  import sme_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       p;
    logic       last;
    logic       drop;
  } item_t;

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  d;
    logic        s;
    logic        p;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [15:0] req_chardata = '0;
  logic [1:0]  req_isstring = '0, req_ispattern = '0, req_last = '0;
  logic [1:0]  gnt, rsp_valid;
  logic        rsp_match, rsp_err;
  logic [4:0]  rsp_index;

  sme_job_sched_if eng_if ();

  int unsigned cyc = 0;
  int          tests = 0, fails = 0;

  item_t       items[$];
  int unsigned cyc_q[$];
  ev_t         obs_q[$], exp_q[$];
  logic        exp_err;

  logic [1:0]  r_gnt, r_rsp, r_after_rsp, r_after_gnt;
  logic        r_m, r_e, r_seen;
  logic [4:0]  r_i;
  int          r_wait;

  sme_job_sched #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_chardata  (req_chardata),
    .req_isstring  (req_isstring),
    .req_ispattern (req_ispattern),
    .req_last      (req_last),
    .gnt           (gnt),
    .eng           (eng_if),
    .rsp_valid     (rsp_valid),
    .rsp_match     (rsp_match),
    .rsp_index     (rsp_index),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine-side observer: every qualified character the engine sees
  always @(negedge clk) begin
    ev_t e;
    if (eng_if.eng_isstring || eng_if.eng_ispattern) begin
      e.cyc = cyc;
      e.d   = eng_if.eng_chardata;
      e.s   = eng_if.eng_isstring;
      e.p   = eng_if.eng_ispattern;
      obs_q.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got time %0t required below 500000", $time);
    $fatal(1);
  end

  function automatic logic [20:0] outs();
    return {gnt, eng_if.eng_chardata, eng_if.eng_isstring, eng_if.eng_ispattern,
            rsp_valid, rsp_match, rsp_index, rsp_err};
  endfunction

  task automatic drive_lane(input int r, input item_t it);
    req[r]           = !it.drop;
    req_isstring[r]  = it.s;
    req_ispattern[r] = it.p;
    req_last[r]      = it.last;
    if (r == 0) req_chardata[7:0] = it.d;
    else        req_chardata[15:8] = it.d;
  endtask

  // nstr string chars then npat pattern chars (last on the final one);
  // optionally cut at gap_at with a gap: 0 no qualifier, 1 req dropped, 2 last without pattern
  task automatic build_job(input int nstr, input int npat, input int gap_at, input int gap_kind);
    item_t it;
    items.delete();
    for (int j = 0; j < nstr + npat; j++) begin
      it      = '0;
      it.d    = 8'($urandom_range(33, 126));
      it.s    = (j < nstr);
      it.p    = (j >= nstr);
      it.last = (j == nstr + npat - 1);
      if (j == gap_at) begin
        it.s    = (gap_kind != 0);
        it.p    = 1'b0;
        it.last = (gap_kind == 2);
        it.drop = (gap_kind == 1);
        items.push_back(it);
        break;
      end
      items.push_back(it);
    end
  endtask

  // Reference: which characters reach the engine and whether the job is in error.
  task automatic model_job();
    int unsigned ns = 0, np = 0;
    ev_t e;
    exp_q.delete();
    exp_err = 1'b0;
    foreach (items[j]) begin
      if (items[j].drop || !(items[j].s || items[j].p) || (items[j].last && !items[j].p)) begin
        exp_err = 1'b1;
        break;
      end
      if ((items[j].s && ns >= STR_MAX) || (items[j].p && np >= PAT_MAX)) begin
        exp_err = 1'b1;
      end else begin
        if (items[j].p && ns == 0) exp_err = 1'b1;
        e.cyc = cyc_q[j];
        e.d   = items[j].d;
        e.s   = items[j].s;
        e.p   = items[j].p;
        exp_q.push_back(e);
        if (items[j].s) ns++;
        if (items[j].p) np++;
      end
      if (items[j].p && items[j].last) break;
    end
  endtask

  // Plays one requester's job and the engine; eng_delay < 0 means the engine never answers.
  task automatic run_job(input int r, input int eng_delay, input logic m, input logic [4:0] idx,
                         input int budget);
    item_t z;
    obs_q.delete();
    cyc_q.delete();
    r_gnt = '0; r_seen = 1'b0; r_rsp = '0; r_m = 1'b0; r_i = '0; r_e = 1'b0; r_wait = 0;
    drive_lane(r, items[0]);
    req[r] = 1'b1;
    for (int k = 0; k < 8 && r_gnt == '0; k++) begin
      @(negedge clk);
      r_gnt = gnt;
    end
    if (r_gnt != '0) begin
      foreach (items[j]) begin
        drive_lane(r, items[j]);
        eng_if.eng_valid       = ($urandom_range(0, 2) == 0);
        eng_if.eng_match       = 1'($urandom);
        eng_if.eng_match_index = 5'($urandom);
        @(negedge clk);
        cyc_q.push_back(cyc);
      end
    end
    z = '0;
    z.drop = 1'b1;
    drive_lane(r, z);
    for (int k = 0; k < budget && !r_seen; k++) begin
      eng_if.eng_valid       = (k == eng_delay);
      eng_if.eng_match       = m;
      eng_if.eng_match_index = idx;
      @(negedge clk);
      r_wait = k + 1;
      if (rsp_valid != '0) begin
        r_seen = 1'b1; r_rsp = rsp_valid; r_m = rsp_match; r_i = rsp_index; r_e = rsp_err;
      end
    end
    eng_if.eng_valid = 1'b0;
    @(negedge clk);
    r_after_rsp = rsp_valid;
    r_after_gnt = gnt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs());
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h required 0", outs());
    end
  endtask

  task automatic test_jobs();
    for (int n = 0; n < 14; n++) begin
      int         r, dly, mm;
      logic       m;
      logic [4:0] idx;
      logic [47:0] txt;
      item_t      it;
      r   = $urandom_range(0, 1);
      dly = $urandom_range(0, 3);
      m   = 1'($urandom);
      idx = 5'($urandom);
      if (n == 0) begin
        r = 0; dly = 1; m = 1'b1; idx = 5'd1;
        build_job(4, 2, -1, 0);
        txt = "ABCDBC";
        for (int j = 0; j < 6; j++) begin
          it = items[j];
          it.d = txt[47 - 8*j -: 8];
          items[j] = it;
        end
      end else if (n == 1) begin
        build_job(33, 2, -1, 0);
      end else if (n == 2) begin
        build_job(3, 2, 3, 0);
      end else begin
        int ns, np;
        ns = $urandom_range(0, 34);
        np = $urandom_range(1, 9);
        if ($urandom_range(0, 3) == 0)
          build_job(ns, np, $urandom_range(0, ns + np - 1), $urandom_range(0, 2));
        else
          build_job(ns, np, -1, 0);
        if (n == 13) r = 0;
      end
      run_job(r, dly, m, idx, 12);
      model_job();
      tests++;
      if (r_gnt !== 2'(1 << r)) begin
        fails++;
        $display("FAIL job%0d grant: got %b required %b", n, r_gnt, 2'(1 << r));
      end
      tests++;
      if (obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL job%0d stream_len: got %0d required %0d", n, obs_q.size(), exp_q.size());
      end else begin
        mm = 0;
        foreach (exp_q[j]) if (obs_q[j] !== exp_q[j]) mm++;
        tests++;
        if (mm != 0) begin
          fails++;
          $display("FAIL job%0d stream: got %0d differing characters required 0", n, mm);
        end
      end
      tests++;
      if (!r_seen || r_rsp !== 2'(1 << r)) begin
        fails++;
        $display("FAIL job%0d rsp_valid: got %b (seen %0d) required %b", n, r_rsp, r_seen, 2'(1 << r));
      end
      tests++;
      if ({r_m, r_i, r_e} !== {m, idx, exp_err}) begin
        fails++;
        $display("FAIL job%0d payload: got m=%0d i=%0d e=%0d required m=%0d i=%0d e=%0d",
                 n, r_m, r_i, r_e, m, idx, exp_err);
      end
      tests++;
      if ({r_after_rsp, r_after_gnt} !== 4'b0000) begin
        fails++;
        $display("FAIL job%0d release: got rsp_valid=%b gnt=%b required 00 00", n, r_after_rsp, r_after_gnt);
      end
    end
  endtask

  task automatic test_reset_midload();
    item_t z;
    logic  g, seen;
    build_job(10, 1, -1, 0);
    drive_lane(0, items[0]);
    g = 1'b0;
    for (int k = 0; k < 8 && !g; k++) begin
      @(negedge clk);
      g = gnt[0];
    end
    for (int j = 0; j < 3; j++) begin
      drive_lane(0, items[j]);
      @(negedge clk);
    end
    tests++;
    if ({g, eng_if.eng_isstring, eng_if.eng_chardata} !== {2'b11, items[2].d}) begin
      fails++;
      $display("FAIL midload_forward: got g=%0d s=%0d d=%h required 1 1 %h",
               g, eng_if.eng_isstring, eng_if.eng_chardata, items[2].d);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL async_reset_outputs: got %h required 0", outs());
    end
    z = '0;
    z.drop = 1'b1;
    drive_lane(0, z);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != '0 || gnt != '0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abandoned_job: got activity %0d required 0", seen);
    end
  endtask

  task automatic test_rr();
    int         exp_idx = 0;
    logic [1:0] g;
    req_chardata  = 16'h2211;
    req_isstring  = '0;
    req_ispattern = 2'b11;
    req_last      = 2'b11;
    req           = 2'b11;
    for (int n = 0; n < 3; n++) begin
      g = '0;
      for (int k = 0; k < 8 && g == '0; k++) begin
        @(negedge clk);
        g = gnt;
      end
      tests++;
      if (g !== 2'(1 << exp_idx)) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b required %b", n, g, 2'(1 << exp_idx));
      end
      @(negedge clk);
      eng_if.eng_valid       = 1'b1;
      eng_if.eng_match       = 1'b1;
      eng_if.eng_match_index = 5'(n);
      @(negedge clk);
      eng_if.eng_valid = 1'b0;
      tests++;
      if (rsp_valid !== 2'(1 << exp_idx)) begin
        fails++;
        $display("FAIL rr_rsp%0d: got %b required %b", n, rsp_valid, 2'(1 << exp_idx));
      end
      if (n == 2) req = '0;
      @(negedge clk);
      tests++;
      if (gnt !== 2'b00) begin
        fails++;
        $display("FAIL rr_idle_gap%0d: got %b required 00", n, gnt);
      end
      exp_idx = 1 - exp_idx;
    end
    req_ispattern = '0;
    req_last      = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    build_job(2, 1, -1, 0);
`ifdef SME_JOB_SCHED_TIMEOUT_EN
    run_job(1, -1, 1'b1, 5'd9, 20);
    tests++;
    if (!r_seen || r_wait != 8 || r_rsp !== 2'b10) begin
      fails++;
      $display("FAIL timeout_latency: got seen=%0d wait=%0d rsp=%b required 1 8 10", r_seen, r_wait, r_rsp);
    end
    tests++;
    if ({r_m, r_i, r_e} !== {1'b0, 5'd0, 1'b1}) begin
      fails++;
      $display("FAIL timeout_payload: got m=%0d i=%0d e=%0d required 0 0 1", r_m, r_i, r_e);
    end
`else
    run_job(1, 30, 1'b1, 5'd9, 40);
    tests++;
    if (!r_seen || r_wait != 31 || r_rsp !== 2'b10) begin
      fails++;
      $display("FAIL long_wait: got seen=%0d wait=%0d rsp=%b required 1 31 10", r_seen, r_wait, r_rsp);
    end
    tests++;
    if ({r_m, r_i, r_e} !== {1'b1, 5'd9, 1'b0}) begin
      fails++;
      $display("FAIL long_wait_payload: got m=%0d i=%0d e=%0d required 1 9 0", r_m, r_i, r_e);
    end
`endif
  endtask

  initial begin
    eng_if.eng_valid       = 1'b0;
    eng_if.eng_match       = 1'b0;
    eng_if.eng_match_index = '0;
    test_reset();
    test_jobs();
    test_reset_midload();
    test_rr();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sme_job_sched.md
SME_JOB_SCHED -- requirements
Module: sme_job_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the WAIT-state cycle limit when SME_JOB_SCHED_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  in  2  per-requester job request, held until its last character is accepted.
REQ-005 SHALL have port req_chardata  in  16  character bus, requester n on bits [8n+7:8n].
REQ-006 SHALL have ports req_isstring and req_ispattern  in  2 each  per-requester character qualifiers.
REQ-007 SHALL have port req_last  in  2  marks the final pattern character.
REQ-008 SHALL have port gnt  out  2  one-hot grant, held for the whole job.
REQ-009 SHALL have ports eng_chardata (8), eng_isstring (1) and eng_ispattern (1)  out  registered drive to the shared match engine.
REQ-010 SHALL have ports eng_valid (1), eng_match (1) and eng_match_index (5)  in  engine result.
REQ-011 SHALL have ports rsp_valid (2), rsp_match (1), rsp_index (5) and rsp_err (1)  out  per-requester result pulse with shared payload.

Function
REQ-012 SHALL implement states IDLE, LOAD, WAIT and RESP.
REQ-013 IDLE: when any req bit is set, SHALL grant round-robin, starting from the requester after the last served one, and SHALL move to LOAD in the next cycle.
REQ-014 LOAD: SHALL forward the granted requester's chardata and qualifiers to the engine with exactly 1 cycle of register latency.
REQ-015 Non-granted requester inputs SHALL be ignored.
REQ-016 SHALL count string characters (6-bit counter) and pattern characters (4-bit counter).
REQ-017 A string character beyond 32, or a pattern character beyond 8, SHALL NOT be forwarded and SHALL set the sticky error flag.
REQ-018 A pattern character seen before any string character SHALL set the error flag; it SHALL still be forwarded.
REQ-019 A granted cycle with neither qualifier set, before req_last, SHALL set the error flag and move to WAIT, because the engine begins comparing on any idle input cycle.
REQ-020 req_last accepted with ispattern SHALL move to WAIT.
REQ-021 req_last asserted without ispattern SHALL be treated as a gap, per REQ-019.
REQ-022 Both engine qualifiers SHALL be 0 in every state other than LOAD.
REQ-023 WAIT: on eng_valid, SHALL capture eng_match and eng_match_index into rsp_match and rsp_index and move to RESP.
REQ-024 RESP: SHALL pulse rsp_valid[granted] for exactly 1 cycle with rsp_err equal to the error flag.
REQ-025 On leaving RESP, SHALL clear gnt, update the round-robin pointer and return to IDLE.
REQ-026 eng_valid arriving in any state other than WAIT SHALL be ignored.
REQ-027 Dropping req mid-LOAD SHALL be treated as a gap, per REQ-019.
REQ-028 A new request from the served requester SHALL NOT be granted before the cycle after RESP.
REQ-029 If both requesters request simultaneously in IDLE, the round-robin pointer SHALL decide the grant.

Reset
REQ-030 On reset assertion, asynchronously and regardless of state, SHALL clear to 0: state (IDLE), gnt, all eng_* outputs, rsp_valid, rsp_match, rsp_index, rsp_err, the counters and the error flag.
REQ-031 On reset, the round-robin pointer SHALL give requester 0 priority.
REQ-032 A job in progress at reset SHALL be abandoned with no response pulse.

Configuration
REQ-033 With SME_JOB_SCHED_TIMEOUT_EN defined, SHALL count cycles in WAIT.
REQ-034 With SME_JOB_SCHED_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without eng_valid SHALL force RESP with rsp_err=1, rsp_match=0 and rsp_index=0.
REQ-035 Without SME_JOB_SCHED_TIMEOUT_EN, there SHALL be no counter and WAIT SHALL persist until eng_valid.

Structure
REQ-036 Package sme_pkg SHALL hold the state enum, STR_MAX=32, PAT_MAX=8 and the character constants (hat 0x5E, dot 0x2E, dollar 0x24).
REQ-037 Two-way round-robin grant logic SHALL be the sub-module sme_rr_arb.

Verification
REQ-038 Requester 0 only, string "ABCD" then pattern "BC" with last; engine returns valid, match=1, index=1 -> gnt=01, engine sees the same 6 characters 1 cycle late, rsp_valid=01, match=1, index=1, err=0.
REQ-039 Both req asserted from reset -> requester 0 is served first, then requester 1, then requester 0 again while both keep requesting.
REQ-040 33 string characters and 2 pattern characters -> 32 forwarded, rsp_err=1.
REQ-041 Gap after 3 string characters -> state moves to WAIT; after engine valid, rsp_err=1.
REQ-042 TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and no eng_valid -> rsp_valid after 8 WAIT cycles with err=1, match=0, index=0.
REQ-043 Reset asserted mid-LOAD -> all outputs read 0 immediately, and no rsp_valid follows.
